// File: rtl/tm_input_conditioner_pkg.sv
// Shared debounce state encoding and counter sizing for the Turing machine input conditioner.
package tm_input_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} debounce_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000;

  // Width of the stability counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/tm_input_conditioner_if.sv
// Raw button/switch inputs and conditioned pulse/data outputs feeding the Turing machine core.
interface tm_input_conditioner_if #(
  parameter int unsigned DATA_W = 7
);
  logic              next_raw;
  logic              done_raw;
  logic [DATA_W-1:0] data_raw;
  logic              next_pulse;
  logic              done_pulse;
  logic [DATA_W-1:0] data_out;

  modport master (
    output next_raw, done_raw, data_raw,
    input  next_pulse, done_pulse, data_out
  );

  modport slave (
    input  next_raw, done_raw, data_raw,
    output next_pulse, done_pulse, data_out
  );
endinterface

// File: rtl/tm_input_conditioner_debounce_fsm.sv
// Press/release debouncer: confirm is combinational on the edge entering HELD (DEBOUNCE_CYCLES+1 stable samples).
// Latency: HELD entered at edge E(DEBOUNCE_CYCLES) after raw is first sampled high; no backpressure.
module debounce_fsm
  import tm_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic confirm,
  output logic held
);
  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  debounce_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cnt_done;

  assign cnt_done = (cnt_q == CNT_LAST);
  assign held     = (state_q == HELD) || (state_q == RELEASE_WAIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    confirm = 1'b0;
    case (state_q)
      IDLE: begin
        if (raw) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!raw) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          state_d = HELD;
          confirm = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!raw) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high returns to HELD silently: one press, one confirm.
        if (raw) begin
          state_d = HELD;
        end else if (cnt_done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/tm_input_conditioner.sv
// Debounces Next/Done into single-cycle pulses and latches switch data on an accepted Next.
// Latency: data_out at E(N), pulse E(N+1)..E(N+2) after first high sample E0; no backpressure.
module tm_input_conditioner
  import tm_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned DATA_W          = 7
) (
  input logic                  clock,
  input logic                  reset_n,
  tm_input_conditioner_if.slave io
);
  logic              next_confirm, done_confirm;
  logic              next_held, done_held;
  logic              next_hit_q, next_hit_d;
  logic              done_hit_q, done_hit_d;
  logic              next_pulse_q, done_pulse_q;
  logic [DATA_W-1:0] data_q, data_d;

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (io.next_raw),
    .confirm (next_confirm),
    .held    (next_held)
  );

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_done_db (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (io.done_raw),
    .confirm (done_confirm),
    .held    (done_held)
  );

  // Done wins a same-edge collision; the losing Next press is consumed, not retried.
  always_comb begin
    done_hit_d = done_confirm;
    next_hit_d = next_confirm && !done_confirm;
    data_d     = next_hit_d ? io.data_raw : data_q;
  end

  // The hit stage gives data_out a full cycle of setup ahead of next_pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      next_hit_q   <= 1'b0;
      done_hit_q   <= 1'b0;
      next_pulse_q <= 1'b0;
      done_pulse_q <= 1'b0;
      data_q       <= '0;
    end else begin
      next_hit_q   <= next_hit_d;
      done_hit_q   <= done_hit_d;
      next_pulse_q <= next_hit_q;
      done_pulse_q <= done_hit_q;
      data_q       <= data_d;
    end
  end

  assign io.next_pulse = next_pulse_q;
  assign io.done_pulse = done_pulse_q;
  assign io.data_out   = data_q;

  a_pulse_excl : assert property (@(posedge clock) disable iff (!reset_n)
    !(next_pulse_q && done_pulse_q));
  a_next_held  : assert property (@(posedge clock) disable iff (!reset_n)
    next_pulse_q |-> next_held);
  a_done_held  : assert property (@(posedge clock) disable iff (!reset_n)
    done_pulse_q |-> done_held);

endmodule

// File: tb/tb_tm_input_conditioner.sv
// Bench for tm_input_conditioner: vector table, directed corner sequences, random run-length model check.
module tb_tm_input_conditioner;
  localparam int D = 4;
  localparam int W = 7;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  tm_input_conditioner_if #(.DATA_W(W)) bus ();

  tm_input_conditioner #(.DEBOUNCE_CYCLES(D), .DATA_W(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_np  = 0;
  int cnt_dp  = 0;

  // Reference model: accepted level flips after D+1 consecutive disagreeing samples.
  logic         m_lvl [2];
  int           m_run [2];
  logic         m_pend_n, m_pend_d, m_np, m_dp;
  logic [W-1:0] m_data;

  typedef struct {
    logic         rst_n;
    logic         nr;
    logic         dr;
    logic [W-1:0] d;
    logic         e_np;
    logic         e_dp;
    logic [W-1:0] e_data;
  } vec_t;
  vec_t tbl [11];

  int   n_len, d_len, at;
  logic nl, dl;
  logic [W-1:0] saved;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 1'b0;
      m_run[i] = 0;
    end
    m_pend_n = 1'b0;
    m_pend_d = 1'b0;
    m_np     = 1'b0;
    m_dp     = 1'b0;
    m_data   = '0;
  endtask

  task automatic model_edge();
    logic r [2];
    logic conf [2];
    r[0] = bus.next_raw;
    r[1] = bus.done_raw;
    m_np = m_pend_n;
    m_dp = m_pend_d;
    for (int i = 0; i < 2; i++) begin
      conf[i] = 1'b0;
      if (r[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_lvl[i] = r[i];
          m_run[i] = 0;
          conf[i]  = r[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pend_d = conf[1];
    m_pend_n = conf[0] && !conf[1];
    if (m_pend_n) m_data = bus.data_raw;
  endtask

  // One clock: drive at negedge, model on posedge, compare at the following negedge.
  task automatic cyc(input logic nr, input logic dr, input logic [W-1:0] d);
    bus.next_raw = nr;
    bus.done_raw = dr;
    bus.data_raw = d;
    @(posedge clock);
    if (reset_n) model_edge();
    else         model_reset();
    @(negedge clock);
    check("model_next_pulse", bus.next_pulse, m_np);
    check("model_done_pulse", bus.done_pulse, m_dp);
    check("model_data_out", bus.data_out, m_data);
    check("pulse_exclusive", bus.next_pulse & bus.done_pulse, 0);
    cnt_np += int'(bus.next_pulse);
    cnt_dp += int'(bus.done_pulse);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, W'($urandom));
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.next_raw = 1'b1;
    bus.done_raw = 1'b1;
    bus.data_raw = 7'h7F;
    model_reset();

    // Reset with buttons held, then a clean Next press with 0x2A.
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0, 7'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0, 7'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b0, 7'h00}; // E0
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b0, 7'h00};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b0, 7'h00};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b0, 7'h00};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b0, 7'h2A}; // E4
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 7'h2A, 1'b1, 1'b0, 7'h2A}; // E5
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b0, 7'h2A};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b0, 7'h2A};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b0, 7'h2A};

    @(negedge clock);
    check("reset_next_pulse", bus.next_pulse, 0);
    check("reset_done_pulse", bus.done_pulse, 0);
    check("reset_data_out", bus.data_out, 0);

    for (int i = 0; i < 11; i++) begin
      reset_n = tbl[i].rst_n;
      cyc(tbl[i].nr, tbl[i].dr, tbl[i].d);
      check("tbl_next_pulse", bus.next_pulse, tbl[i].e_np);
      check("tbl_done_pulse", bus.done_pulse, tbl[i].e_dp);
      check("tbl_data_out", bus.data_out, tbl[i].e_data);
    end

    // Bounce: 3-high/1-low never reaches D+1 stable samples.
    idle(8);
    cnt_np = 0;
    for (int i = 0; i < 40; i++) cyc((i % 4) != 3, 1'b0, W'($urandom));
    check("bounce_next_count", cnt_np, 0);
    check("bounce_data_out", bus.data_out, 7'h2A);

    // Long hold gives one pulse; short release is absorbed; full release re-arms.
    cnt_dp = 0;
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, 7'h01);
    check("hold_done_count", cnt_dp, 1);
    cnt_dp = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 7'h01);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 7'h01);
    check("short_release_count", cnt_dp, 0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 7'h01);
    cnt_dp = 0;
    at = -1;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, 7'h01);
      if (bus.done_pulse && at < 0) at = k;
    end
    check("repress_done_count", cnt_dp, 1);
    check("repress_done_edge", at, D + 1);

    // Collision: Done wins, Next consumed until released and re-pressed.
    idle(8);
    cnt_np = 0;
    cnt_dp = 0;
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 7'h15);
    check("coll_done_count", cnt_dp, 1);
    check("coll_next_count", cnt_np, 0);
    check("coll_data_out", bus.data_out, 7'h2A);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 7'h15);
    check("coll_next_still_held", cnt_np, 0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 7'h15);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 7'h33);
    check("coll_repress_next", cnt_np, 1);
    check("coll_repress_data", bus.data_out, 7'h33);

    // Data changing every cycle: captured value is the one at the confirm edge.
    idle(8);
    saved = '0;
    for (int k = 0; k < 9; k++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      if (k == D) saved = d;
      cyc(1'b1, 1'b0, d);
      if (k >= D && k <= D + 2) check("stable_data_out", bus.data_out, saved);
      if (k == D + 1) check("stable_next_pulse", bus.next_pulse, 1);
    end

    // Reset during PRESS_WAIT, button still held afterwards.
    idle(8);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 7'h11);
    reset_n = 1'b0;
    #1;
    check("midrst_next_pulse", bus.next_pulse, 0);
    check("midrst_data_out", bus.data_out, 0);
    cyc(1'b1, 1'b0, 7'h11);
    cyc(1'b1, 1'b0, 7'h11);
    reset_n = 1'b1;
    cnt_np = 0;
    at = -1;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b0, 7'h22);
      if (bus.next_pulse && at < 0) at = k;
    end
    check("midrst_next_count", cnt_np, 1);
    check("midrst_pulse_edge", at, D + 1);
    check("midrst_data", bus.data_out, 7'h22);

    // Random run-length stimulus with occasional resets against the model.
    n_len = 1;
    d_len = 1;
    nl = 1'b1;
    dl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      n_len--;
      if (n_len == 0) begin
        nl    = ~nl;
        n_len = $urandom_range(1, 12);
      end
      d_len--;
      if (d_len == 0) begin
        dl    = ~dl;
        d_len = $urandom_range(1, 12);
      end
      reset_n = ($urandom_range(0, 499) != 0);
      cyc(nl, dl, W'($urandom));
    end
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
